zp_sub_stream_ctrl: RTL and testbench



---
 rtl/zp_sub_stream_ctrl_pkg.sv | 15 +
 rtl/sync_fifo_fwd.sv | 68 ++++++
 rtl/zp_sub_stream_ctrl.sv | 134 +++++++++++++
 tb/tb_zp_sub_stream_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zp_sub_stream_ctrl_pkg.sv
// Shared types and constants for the zero-point subtraction stream controller.
package zp_sub_stream_ctrl_pkg;

    localparam int PIX_W  = 8;
    localparam int LANES  = 8;
    localparam int WORD_W = PIX_W * LANES;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/sync_fifo_fwd.sv
// Synchronous FIFO; the head entry is presented from storage flops with a valid flag and occupancy count.
module sync_fifo_fwd #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_fire, rd_fire;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rd_fire  = rd_en && (count_q != '0);
        // A write while full is accepted only when the head leaves in the same cycle.
        wr_fire  = wr_en && ((count_q != FULL) || rd_fire);
        if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; cleared pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data  = mem[rd_ptr_q];
    assign rd_valid = (count_q != '0);
    assign count    = count_q;

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && (count_q == FULL) && !rd_fire));

endmodule

// File: rtl/zp_sub_stream_ctrl.sv
// Tile sequencer for the 8-lane zero-point subtraction datapath: credit-metered issue,
// output FIFO for the fixed-latency results, and tile completion signalling.
module zp_sub_stream_ctrl
    import zp_sub_stream_ctrl_pkg::*;
#(
    parameter int DP_LAT     = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PIX_W-1:0]   cfg_zero_point,
    input  logic [CNT_W-1:0]   cfg_num_words,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WORD_W-1:0]  s_data,
    output logic [PIX_W-1:0]   dp_zero_point,
    output logic [WORD_W-1:0]  dp_data_in,
    input  logic [WORD_W-1:0]  dp_data_out,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WORD_W-1:0]  m_data,
    output logic               m_last,
    output logic               busy,
    output logic               done
);

    localparam int FC_W = $clog2(FIFO_DEPTH) + 1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [PIX_W-1:0]    zp_q, zp_d;
    logic [WORD_W-1:0]   din_q, din_d;
    // Bit 0 tracks the word held in dp_data_in; bits 1..DP_LAT follow it through the datapath.
    logic [DP_LAT:0]     vld_q, vld_d;
    logic [DP_LAT:0]     lst_q, lst_d;

    logic [FC_W-1:0]     fifo_count;
    logic [WORD_W:0]     fifo_rd;
    logic                fifo_valid;
    logic [31:0]         inflight;
    logic                credit_ok;
    logic                accept;
    logic                pop;

    assign inflight  = $countones(vld_q);
    assign credit_ok = (32'(fifo_count) + inflight) < 32'(FIFO_DEPTH);

    assign m_valid = fifo_valid;
    assign m_data  = fifo_rd[WORD_W-1:0];
    assign m_last  = fifo_valid & fifo_rd[WORD_W];
    assign pop     = m_valid && m_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        zp_d        = zp_q;
        cfg_ready   = 1'b0;
        s_ready     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    zp_d        = cfg_zero_point;
                    remaining_d = cfg_num_words;
                    state_d     = (cfg_num_words == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                s_ready = (remaining_q != '0) && credit_ok;
                accept  = s_valid && s_ready;
                if (accept) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && m_last && (inflight == '0)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        din_d = accept ? s_data : din_q;
        vld_d = {vld_q[DP_LAT-1:0], accept};
        lst_d = {lst_q[DP_LAT-1:0], accept && (remaining_q == CNT_W'(1))};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            zp_q        <= '0;
            din_q       <= '0;
            vld_q       <= '0;
            lst_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            zp_q        <= zp_d;
            din_q       <= din_d;
            vld_q       <= vld_d;
            lst_q       <= lst_d;
        end
    end

    assign dp_zero_point = zp_q;
    assign dp_data_in    = din_q;

    sync_fifo_fwd #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (vld_q[DP_LAT]),
        .wr_data  ({lst_q[DP_LAT], dp_data_out}),
        .rd_en    (m_ready),
        .rd_data  (fifo_rd),
        .rd_valid (fifo_valid),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_zp_sub_stream_ctrl.sv
// Randomized bench for zp_sub_stream_ctrl: a behavioural datapath beside the DUT and a
// queue-based reference of accepted words, tile boundaries and handshake rules.
module tb_zp_sub_stream_ctrl;

    localparam int DP_LAT     = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [7:0]        cfg_zero_point;
    logic [CNT_W-1:0]  cfg_num_words;
    logic              s_valid;
    logic              s_ready;
    logic [63:0]       s_data;
    logic [7:0]        dp_zero_point;
    logic [63:0]       dp_data_in;
    logic [63:0]       dp_data_out;
    logic              m_valid;
    logic              m_ready;
    logic [63:0]       m_data;
    logic              m_last;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    zp_sub_stream_ctrl #(
        .DP_LAT     (DP_LAT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_zero_point (cfg_zero_point),
        .cfg_num_words  (cfg_num_words),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .dp_zero_point  (dp_zero_point),
        .dp_data_in     (dp_data_in),
        .dp_data_out    (dp_data_out),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .busy           (busy),
        .done           (done)
    );

    function automatic logic [63:0] sub_word(input logic [63:0] w, input logic [7:0] zp);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = w[8*i +: 8] - zp;
        return r;
    endfunction

    // Behavioural datapath: lane-wise subtraction, DP_LAT register stages.
    logic [63:0] dp_pipe [DP_LAT];
    always @(posedge clk) begin
        dp_pipe[0] <= sub_word(dp_data_in, dp_zero_point);
        for (int i = 1; i < DP_LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign dp_data_out = dp_pipe[DP_LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state, owned by the monitor process.
    logic [64:0] exp_q [$];
    bit          busy_exp, done_exp, prev_hold, prev_last;
    logic [7:0]  zp_exp;
    logic [63:0] prev_data, first_out_word;
    int          cur_num, tile_acc, out_cnt, first_acc_cyc;
    int          tiles_done = 0;
    bit          lat_chk = 1'b0;

    always @(negedge clk) begin
        int          outstanding;
        bit          s_ready_exp, busy_n, done_n;
        logic [64:0] e;
        if (rst) begin
            exp_q.delete();
            busy_exp  = 1'b0;
            done_exp  = 1'b0;
            prev_hold = 1'b0;
            zp_exp    = 8'h00;
            cur_num   = 0;
            tile_acc  = 0;
            out_cnt   = 0;
        end else begin
            outstanding = exp_q.size();
            s_ready_exp = busy_exp && (tile_acc < cur_num) && (outstanding < FIFO_DEPTH);
            check("busy",          65'(busy),          65'(busy_exp));
            check("done",          65'(done),          65'(done_exp));
            check("cfg_ready",     65'(cfg_ready),     65'(!busy_exp && !done_exp));
            check("dp_zero_point", 65'(dp_zero_point), 65'(zp_exp));
            check("s_ready",       65'(s_ready),       65'(s_ready_exp));
            if (prev_hold) begin
                check("hold_valid", 65'(m_valid), 65'(1'b1));
                check("hold_data",  65'(m_data),  65'(prev_data));
                check("hold_last",  65'(m_last),  65'(prev_last));
            end
            if (m_valid) check("m_valid_spurious", 65'(outstanding != 0), 65'(1'b1));

            busy_n = busy_exp;
            done_n = 1'b0;
            if (cfg_valid && !busy_exp && !done_exp) begin
                zp_exp   = cfg_zero_point;
                cur_num  = int'(cfg_num_words);
                tile_acc = 0;
                out_cnt  = 0;
                if (cfg_num_words == '0) done_n = 1'b1;
                else                     busy_n = 1'b1;
            end
            if (s_valid && s_ready) begin
                if (tile_acc == 0) first_acc_cyc = cyc;
                exp_q.push_back({tile_acc == cur_num - 1, sub_word(s_data, zp_exp)});
                tile_acc++;
            end
            if (m_valid && m_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("m_data", 65'(m_data), 65'(e[63:0]));
                check("m_last", 65'(m_last), 65'(e[64]));
                if (out_cnt == 0) begin
                    first_out_word = m_data;
                    if (lat_chk) check("latency", 65'(cyc - first_acc_cyc), 65'(DP_LAT + 2));
                end
                out_cnt++;
                if (e[64]) begin
                    busy_n = 1'b0;
                    done_n = 1'b1;
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            if (done_exp) tiles_done++;
            done_exp = done_n;
            busy_exp = busy_n;
        end
    end

    task automatic check_reset_outputs();
        check("rst_cfg_ready", 65'(cfg_ready),     65'(1'b1));
        check("rst_s_ready",   65'(s_ready),       65'(1'b0));
        check("rst_m_valid",   65'(m_valid),       65'(1'b0));
        check("rst_m_last",    65'(m_last),        65'(1'b0));
        check("rst_busy",      65'(busy),          65'(1'b0));
        check("rst_done",      65'(done),          65'(1'b0));
        check("rst_zero_point",65'(dp_zero_point), 65'(8'h00));
        check("rst_data_in",   65'(dp_data_in),    65'(64'h0));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        cfg_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // mode 0: streaming pattern, 1: m_ready 1-in-4, 2: random, 3: streaming plus config spam
    task automatic run_tile(input logic [7:0] zp, input int n, input int mode,
                            input int abort_at, input int pv, input int pr);
        int          start, sent, budget;
        bit          ok;
        logic [63:0] word;
        start  = tiles_done;
        sent   = 0;
        budget = 0;
        word   = (mode == 2) ? {$urandom, $urandom} : 64'h0706050403020100;
        cfg_valid      = 1'b1;
        cfg_zero_point = zp;
        cfg_num_words  = CNT_W'(n);
        @(negedge clk);
        ok = cfg_ready;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        check("cfg_accept", 65'(ok), 65'(1'b1));
        if (!ok) begin
            pulse_reset();
            return;
        end
        while (tiles_done == start && budget < 20000) begin
            s_valid = (sent < n) && ((mode == 2) ? ($urandom_range(0, 99) < pv) : 1'b1);
            s_data  = word;
            case (mode)
                1:       m_ready = (cyc % 4 == 0);
                2:       m_ready = ($urandom_range(0, 99) < pr);
                default: m_ready = 1'b1;
            endcase
            cfg_valid = (mode == 3) && (budget >= 1) && (budget <= 4);
            if (mode == 3) begin
                cfg_zero_point = 8'h10;
                cfg_num_words  = CNT_W'(7);
            end
            @(negedge clk);
            if (s_valid && s_ready) begin
                sent++;
                word = (mode == 2) ? {$urandom, $urandom} : word + 64'h0808080808080808;
            end
            if (abort_at >= 0 && sent == abort_at) begin
                rst = 1'b1;
                #1 check_reset_outputs();
                s_valid   = 1'b0;
                cfg_valid = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            @(posedge clk);
            #1 budget++;
        end
        s_valid   = 1'b0;
        cfg_valid = 1'b0;
        check("tile_complete", 65'(tiles_done != start), 65'(1'b1));
        if (tiles_done == start) pulse_reset();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        rst            = 1'b1;
        cfg_valid      = 1'b0;
        cfg_zero_point = 8'h00;
        cfg_num_words  = '0;
        s_valid        = 1'b0;
        s_data         = 64'h0;
        m_ready        = 1'b0;
        #1 check_reset_outputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic tile with latency and first-word checks.
        lat_chk = 1'b1;
        run_tile(8'hFD, 4, 0, -1, 100, 100);
        lat_chk = 1'b0;
        check("basic_first_word", 65'(first_out_word), 65'(64'h0A09080706050403));
        check("basic_count",      65'(out_cnt),        65'(4));

        // Backpressure: the FIFO fills and s_ready must follow the credit rule.
        run_tile(8'h05, 32, 1, -1, 100, 100);
        check("bp_count", 65'(out_cnt), 65'(32));

        // Zero-length tile.
        run_tile(8'h7F, 0, 0, -1, 100, 100);
        check("zero_count", 65'(out_cnt), 65'(0));

        // Configuration offered mid-tile must be ignored.
        run_tile(8'h22, 20, 3, -1, 100, 100);
        check("spam_count", 65'(out_cnt), 65'(20));

        // Reset after 5 of 10 words, then a fresh tile.
        run_tile(8'h81, 10, 0, 5, 100, 100);
        run_tile(8'h01, 6, 0, -1, 100, 100);
        check("post_reset_count", 65'(out_cnt), 65'(6));

        // Random stress.
        for (int t = 0; t < 300; t++) begin
            len = (t % 10 == 0) ? int'($urandom_range(1, 300)) : int'($urandom_range(1, 24));
            run_tile(8'($urandom), len, 2, -1,
                     int'($urandom_range(30, 100)), int'($urandom_range(30, 100)));
            check("rand_count", 65'(out_cnt), 65'(len));
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
